// File: rtl/riscv_pkg.sv
// Shared RV32I encoding definitions: format selector, opcodes, the NOP word
// substituted on errors, and the legal immediate ranges per format.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;
  localparam logic signed [31:0] IMMJ_MIN  = -32'sd1048576;
  localparam logic signed [31:0] IMMJ_MAX  = 32'sd1048574;

  function automatic logic imm_in_range(input logic signed [31:0] v,
                                        input logic signed [31:0] lo,
                                        input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry registered FIFO; the head is read straight from storage, so the
// output only changes on a clock edge. Full blocks pushes even when popping.
module enc_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = ~wptr_q;
    if (pop_ok)  rptr_d = ~rptr_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) mem_q[wptr_q] <= wdata_i;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ins_encoder.sv
// Packs RV32I fields into a 32-bit instruction word, substituting NOP on any
// illegal format or immediate, and queues {err, ins} through a 2-entry FIFO.
module ins_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic        out_err,
  output logic [7:0]  err_cnt
);
  import riscv_pkg::*;

  logic signed [31:0] imm_s;
  logic [31:0]        raw_ins;
  logic [31:0]        pack_ins;
  logic               pack_err;
  logic               accept;
  logic               fifo_full, fifo_empty;
  logic [32:0]        head;
  logic [7:0]         err_cnt_q, err_cnt_d;

  assign imm_s = $signed(in_imm);

  always_comb begin
    raw_ins  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
    pack_err = 1'b0;
    case (in_fmt)
      FMT_R: begin
        raw_ins = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_I: begin
        raw_ins  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        pack_err = !imm_in_range(imm_s, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        raw_ins  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        pack_err = !imm_in_range(imm_s, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        raw_ins  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        pack_err = !imm_in_range(imm_s, IMMB_MIN, IMMB_MAX) || in_imm[0];
      end
      FMT_U: begin
        raw_ins  = {in_imm[31:12], in_rd, in_opcode};
        pack_err = (in_imm[11:0] != 12'd0);
      end
      FMT_J: begin
        raw_ins  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                    in_rd, in_opcode};
        pack_err = !imm_in_range(imm_s, IMMJ_MIN, IMMJ_MAX) || in_imm[0];
      end
      default: pack_err = 1'b1;
    endcase
    pack_ins = pack_err ? NOP : raw_ins;
  end

  assign in_ready  = !fifo_full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign out_ins   = head[31:0];
  assign out_err   = head[32];

  enc_fifo2 #(.WIDTH(33)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .wdata_i ({pack_err, pack_ins}),
    .pop_i   (out_ready),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Saturates rather than wrapping so a long error burst stays visible.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && pack_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ins_encoder.sv
// Bench for ins_encoder: directed vector table, hand-written flow-control
// sequences, and randomized traffic against an arithmetic reference model.
module tb_ins_encoder;
  import riscv_pkg::*;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_ins;
  logic        out_err;
  logic [7:0]  err_cnt;

  ins_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_ins(out_ins), .out_err(out_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_ins;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[13];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_cnt  = 0;
  logic [32:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic longint unsigned at(input longint unsigned v, input int sh);
    return v << sh;
  endfunction

  // Reference encoder: bit fields extracted with shifts/masks on 64-bit ints.
  function automatic logic [32:0] ref_enc(input logic [2:0] fmt, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    longint s;
    longint unsigned u, w;
    bit bad;
    s = $signed(imm);
    u = {32'd0, imm};
    w = 0;
    bad = 0;
    case (fmt)
      FMT_R: w = at(f7, 25) | at(rs2, 20) | at(rs1, 15) | at(f3, 12) | at(rd, 7) | 64'(op);
      FMT_I: begin
        bad = (s < -2048) || (s > 2047);
        w = at(u & 'hFFF, 20) | at(rs1, 15) | at(f3, 12) | at(rd, 7) | 64'(op);
      end
      FMT_S: begin
        bad = (s < -2048) || (s > 2047);
        w = at((u >> 5) & 'h7F, 25) | at(rs2, 20) | at(rs1, 15) | at(f3, 12)
          | at(u & 'h1F, 7) | 64'(op);
      end
      FMT_B: begin
        bad = (s < -4096) || (s > 4094) || (s % 2 != 0);
        w = at((u >> 12) & 1, 31) | at((u >> 5) & 'h3F, 25) | at(rs2, 20) | at(rs1, 15)
          | at(f3, 12) | at((u >> 1) & 'hF, 8) | at((u >> 11) & 1, 7) | 64'(op);
      end
      FMT_U: begin
        bad = (u % 4096) != 0;
        w = (u & 'hFFFFF000) | at(rd, 7) | 64'(op);
      end
      FMT_J: begin
        bad = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
        w = at((u >> 20) & 1, 31) | at((u >> 1) & 'h3FF, 21) | at((u >> 11) & 1, 20)
          | at((u >> 12) & 'hFF, 12) | at(rd, 7) | 64'(op);
      end
      default: bad = 1;
    endcase
    if (bad) return {1'b1, 32'h0000_0013};
    return {1'b0, w[31:0]};
  endfunction

  task automatic drive(input vec_t v);
    in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1;
    in_rs2 = v.rs2; in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic acc, pop;
    logic [32:0] e;
    int t;

    vecs[0]  = '{FMT_I, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,          32'h00100193, 1'b0};
    vecs[1]  = '{FMT_S, 7'h23, 5'd0, 5'd1, 5'd1, 3'd0, 7'd0, 32'hFFFFFFE5,   32'hFE1082A3, 1'b0};
    vecs[2]  = '{FMT_B, 7'h63, 5'd0, 5'd1, 5'd0, 3'd7, 7'd0, 32'hFFFFF7EC,   32'hFE00F663, 1'b0};
    vecs[3]  = '{FMT_U, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00FF0000,   32'h00FF00B7, 1'b0};
    vecs[4]  = '{FMT_R, 7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'd0, 32'hDEADBEEF,   32'h007302B3, 1'b0};
    vecs[5]  = '{FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,          32'h008000EF, 1'b0};
    vecs[6]  = '{FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,          32'h00000013, 1'b1};
    vecs[7]  = '{FMT_I, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h00000013, 1'b1};
    vecs[8]  = '{3'd6,  7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0,          32'h00000013, 1'b1};
    vecs[9]  = '{FMT_U, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000123,   32'h00000013, 1'b1};
    vecs[10] = '{FMT_S, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFFF800,   32'h80312023, 1'b0};
    vecs[11] = '{FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,       32'h7E000FE3, 1'b0};
    vecs[12] = '{FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576,    32'h00000013, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(vecs[0]);
    idle_cycles(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_ins", out_ins, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    idle_cycles(1);

    // Directed table: push one, check head after one edge, then pop.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      if (vecs[i].exp_err) exp_cnt++;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_ins", i), out_ins, vecs[i].exp_ins);
      chk($sformatf("vec%0d_err", i), out_err, vecs[i].exp_err);
      chk($sformatf("vec%0d_err_cnt", i), err_cnt, exp_cnt);
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_popped", i), out_valid, 0);
      out_ready = 1'b0;
    end

    // Backpressure: A, B queued while stalled; C offered while full must be dropped.
    drive(vecs[0]); in_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready_after_1", in_ready, 1);
    drive(vecs[1]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_ready_full", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_ins", out_ins, 32'h00100193);
      chk("bp_hold_valid", out_valid, 1);
      @(negedge clk);
    end
    drive(vecs[4]); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_B", out_ins, 32'hFE1082A3);
    @(negedge clk);
    chk("bp_no_push_when_full", out_valid, 0);
    out_ready = 1'b0;

    // Push and pop together while holding one entry.
    drive(vecs[3]); in_valid = 1'b1;
    @(negedge clk);
    drive(vecs[5]); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pp_count1_valid", out_valid, 1);
    chk("pp_count1_ready", in_ready, 1);
    chk("pp_order", out_ins, 32'h008000EF);
    @(negedge clk);
    chk("pp_drained", out_valid, 0);
    out_ready = 1'b0;

    // Randomized traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_valid", out_valid, q.size() != 0);
      chk("rnd_ready", in_ready, q.size() < 2);
      if (q.size() != 0) begin
        chk("rnd_ins", out_ins, q[0][31:0]);
        chk("rnd_err", out_err, q[0][32]);
      end
      chk("rnd_err_cnt", err_cnt, exp_cnt);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_fmt    = 3'($urandom_range(0, 7));
      in_opcode = 7'($urandom); in_rd = 5'($urandom); in_rs1 = 5'($urandom);
      in_rs2    = 5'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
      case ($urandom_range(0, 4))
        0: t = int'($urandom_range(0, 8191)) - 4096;
        1: t = (int'($urandom_range(0, 8191)) - 4096) & ~1;
        2: t = int'($urandom);
        3: t = int'($urandom) & 32'hFFFFF000;
        default: t = int'($urandom_range(0, 2400000)) - 1200000;
      endcase
      in_imm = t;
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() != 0);
      if (pop) void'(q.pop_front());
      if (acc) begin
        e = ref_enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        q.push_back(e);
        if (e[32] && exp_cnt < 255) exp_cnt++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    idle_cycles(3);
    chk("rnd_drained", out_valid, 0);
    q.delete();

    // 260 errored requests saturate the counter.
    drive(vecs[6]); in_valid = 1'b1; out_ready = 1'b1;
    idle_cycles(260);
    in_valid = 1'b0;
    idle_cycles(2);
    chk("sat_err_cnt", err_cnt, 255);
    chk("sat_drained", out_valid, 0);

    // Reset with two words queued and a request still offered.
    out_ready = 1'b0;
    drive(vecs[0]); in_valid = 1'b1;
    idle_cycles(2);
    chk("mr_full", in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_err_cnt", err_cnt, 0);
    chk("mr_out_ins", out_ins, 0);
    chk("mr_out_err", out_err, 0);
    @(negedge clk);
    chk("mr_no_accept_in_reset", out_valid, 0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mr_no_stale", out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ins_encoder.md
INS_ENCODER -- requirements
Module: ins_encoder

Interface
REQ-001 Parameter: none; all widths are fixed by the RV32I format.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 in_valid  in  1  request valid.
REQ-005 in_ready  out  1  encoder can accept a request (queue not full).
REQ-006 in_fmt  in  3  format select (R,I,S,B,U,J; other codes illegal).
REQ-007 in_opcode  in  7  opcode[6:0], copied verbatim.
REQ-008 in_rd, in_rs1, in_rs2  in  5 each  register fields.
REQ-009 in_funct3  in  3; in_funct7  in  7  function fields.
REQ-010 in_imm  in  32  signed immediate value (for U: full 32-bit value, upper 20 bits used).
REQ-011 out_valid  out  1  encoded word available.
REQ-012 out_ready  in  1  consumer accepts the word.
REQ-013 out_ins  out  32  encoded instruction.
REQ-014 out_err  out  1  word was substituted because of an encoding error.
REQ-015 err_cnt  out  8  saturating count of errored requests.

Function
REQ-016 A request is accepted when in_valid && in_ready; packing is combinational into the queue write port.
REQ-017 Packing: R={f7,rs2,rs1,f3,rd,op}; I={imm[11:0],rs1,f3,rd,op}; S={imm[11:5],rs2,rs1,f3,imm[4:0],op}; B={imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U={imm[31:12],rd,op}; J={imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-018 Legality: I/S require imm in [-2048,2047]; B requires imm in [-4096,4094] with imm[0]=0; J requires imm in [-1048576,1048574] with imm[0]=0; U requires imm[11:0]=0; R ignores imm.
REQ-019 Any illegal fmt or range/alignment violation enqueues NOP 32'h00000013 with err=1.
REQ-020 Queue: 2-entry FIFO of {ins,err}, with in_ready = !full and out_valid = !empty; out_ins/out_err come from the head.
REQ-021 Latency: accepted at edge N, visible on out_valid after edge N when the queue was empty; no combinational in-to-out path.
REQ-022 Pop occurs on out_valid && out_ready. Simultaneous push and pop while holding 1 entry keeps the count at 1 and preserves order.
REQ-023 When full, in_ready=0 and no push occurs even if a pop happens in the same cycle.
REQ-024 out_ins/out_err hold stable while out_valid && !out_ready.
REQ-025 err_cnt increments on each accepted errored request and saturates at 255.
REQ-026 Read and write pointers are 1 bit each and wrap modulo 2; the 2-bit count ranges 0..2.

Reset
REQ-027 With rst_n=0 at a clock edge: the queue is emptied (out_valid=0, in_ready=1 the following cycle), out_ins=0, out_err=0, err_cnt=0.
REQ-028 Reset mid-operation discards queued words; requests presented during reset are not accepted.

Structure
REQ-029 Package riscv_pkg holds the fmt enum (FMT_R..FMT_J), opcode constants, the NOP constant and the immediate range constants.
REQ-030 The FIFO is the sub-module enc_fifo2 (width 33, depth 2); packing and legality checking live in ins_encoder.

Verification
REQ-031 I: addi rd=3, rs1=0, f3=0, imm=1, op=0010011 -> out_ins=0x00100193, err=0.
REQ-032 S: sb rs1=1, rs2=1, imm=-27 -> 0xFE1082A3; B: bgeu rs1=1, rs2=0, imm=-2068 -> 0xFE00F663; U: lui rd=1, imm=0x00FF0000 -> 0x00FF00B7.
REQ-033 Error: B with imm=3 -> 0x00000013, out_err=1, err_cnt 0->1; I with imm=2048 -> NOP, err_cnt=2.
REQ-034 Backpressure: out_ready=0, push A and B -> in_ready=0 after the 2nd push; raise out_ready -> A then B, with values stable while stalled.
REQ-035 Simultaneous push/pop at count=1 holds the count at 1 and preserves order; 260 errored requests -> err_cnt=255.
REQ-036 rst_n=0 with 2 words queued -> out_valid=0 and err_cnt=0 on the next cycle; no stale word appears afterwards.
